// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - boot-time instruction memory loader
//
// Purpose: on start, zero-fills instruction memory, then receives a
// length-prefixed little-endian byte stream and writes 32-bit words from
// address 0 while holding the core in stall.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   start                 load request pulse (IDLE/DONE/ERROR only)
//   byte_valid/byte_data  incoming byte stream
//   byte_ready            loader accepts a byte this cycle
//   wr_en/wr_addr/wr_data registered instruction memory write port
//   cpu_hold              core stall
//   done                  image complete, core released
//   err_overflow          declared length larger than memory
//   word_count            image words written in the current load
module imem_boot_loader #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              cpu_hold,
    output logic              done,
    output logic              err_overflow,
    output logic [ADDR_W:0]   word_count
);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_LEN_LO, S_LEN_HI, S_DATA, S_FLUSH, S_DONE, S_ERROR
    } state_t;

    localparam logic [15:0]       DEPTH_N   = 16'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [1:0]        lane_q, lane_d;
    logic [23:0]       buf_q, buf_d;
    logic [ADDR_W:0]   wc_q, wc_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [31:0]       wr_data_q, wr_data_d;

    logic              accept;
    logic [15:0]       n_full;
    logic [ADDR_W:0]   wc_inc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            len_q     <= '0;
            lane_q    <= '0;
            buf_q     <= '0;
            wc_q      <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            lane_q    <= lane_d;
            buf_q     <= buf_d;
            wc_q      <= wc_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    // Handshake readiness depends only on the state register so the
    // source never sees a combinational path through byte_valid.
    assign byte_ready = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                        (state_q == S_DATA);
    assign accept     = byte_valid && byte_ready;
    assign n_full     = {byte_data, len_q[7:0]};
    assign wc_inc     = wc_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        lane_d    = lane_q;
        buf_d     = buf_q;
        wc_d      = wc_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    // First clear write is issued on the same edge that
                    // accepts start.
                    state_d   = S_CLEAR;
                    wr_en_d   = 1'b1;
                    wr_addr_d = '0;
                    wr_data_d = '0;
                    wc_d      = '0;
                    lane_d    = '0;
                    len_d     = '0;
                end
            end
            S_CLEAR: begin
                // wr_addr_q doubles as the clear counter.
                if (wr_addr_q == LAST_ADDR) begin
                    state_d = S_LEN_LO;
                end else begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = wr_addr_q + 1'b1;
                end
            end
            S_LEN_LO: begin
                if (accept) begin
                    len_d[7:0] = byte_data;
                    state_d    = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (accept) begin
                    len_d = n_full;
                    if (n_full == 16'd0) begin
                        state_d = S_FLUSH;
                    end else if (n_full > DEPTH_N) begin
                        state_d = S_ERROR;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    lane_d = lane_q + 2'd1;
                    case (lane_q)
                        2'd0: buf_d[7:0]   = byte_data;
                        2'd1: buf_d[15:8]  = byte_data;
                        2'd2: buf_d[23:16] = byte_data;
                        default: begin
                            wr_en_d   = 1'b1;
                            wr_addr_d = wc_q[ADDR_W-1:0];
                            wr_data_d = {byte_data, buf_q};
                            wc_d      = wc_inc;
                            if (16'(wc_inc) == len_q) begin
                                state_d = S_FLUSH;
                            end
                        end
                    endcase
                end
            end
            S_FLUSH: begin
                // Lets the final write retire before the core is released.
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign wr_en        = wr_en_q;
    assign wr_addr      = wr_addr_q;
    assign wr_data      = wr_data_q;
    assign word_count   = wc_q;
    assign done         = (state_q == S_DONE);
    assign cpu_hold     = (state_q != S_DONE);
    // ERROR is left only through start or reset, which makes this sticky.
    assign err_overflow = (state_q == S_ERROR);

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb/tb_imem_boot_loader.sv - self-checking bench for imem_boot_loader
module tb_imem_boot_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        wr_en;
    logic [5:0]  wr_addr;
    logic [31:0] wr_data;
    logic        cpu_hold;
    logic        done;
    logic        err_overflow;
    logic [6:0]  word_count;

    imem_boot_loader #(.DEPTH(64), .ADDR_W(6)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .byte_ready   (byte_ready),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .cpu_hold     (cpu_hold),
        .done         (done),
        .err_overflow (err_overflow),
        .word_count   (word_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic [7:0] lo;
        logic [7:0] hi;
        int         nwords;
        int         maxgap;
        bit         spec_data;
        bit         exp_err;
        int         exp_wc;
    } vec_t;

    wr_t        sb[$];
    wr_t        mon_e;
    vec_t       vecs[7];
    logic [7:0] spec_bytes[8];
    int         checks = 0;
    int         failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Every write the DUT issues must match the head of the scoreboard.
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write actual addr=%0d data=%h expected none", wr_addr, wr_data);
            end else begin
                mon_e = sb.pop_front();
                chk("wr_addr", 32'(wr_addr), mon_e.addr);
                chk("wr_data", wr_data, mon_e.data);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // Called at a negedge; returns at the negedge right after acceptance.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        byte_valid = 1'b0;
        repeat (gap) @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = b;
        t = 0;
        while (byte_ready !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (byte_ready !== 1'b1) begin
            chk("byte_ready_timeout", 32'(byte_ready), 32'd1);
        end
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic do_start();
        int run;
        start = 1'b1;
        for (int i = 0; i < 64; i++) sb.push_back('{addr: i, data: 32'h0});
        @(negedge clk);
        start = 1'b0;
        chk("start_err_cleared", 32'(err_overflow), 32'd0);
        chk("start_cpu_hold", 32'(cpu_hold), 32'd1);
        run = 0;
        while (wr_en === 1'b1 && run < 70) begin
            if (byte_ready !== 1'b0) chk("clear_byte_ready", 32'(byte_ready), 32'd0);
            @(negedge clk);
            run++;
        end
        chk("clear_cycles", run, 64);
        chk("post_clear_byte_ready", 32'(byte_ready), 32'd1);
    endtask

    task automatic run_vec(input vec_t v);
        logic [31:0] word;
        logic [7:0]  b;
        int          n;
        do_start();
        send_byte(v.lo, $urandom_range(v.maxgap, 0));
        send_byte(v.hi, $urandom_range(v.maxgap, 0));
        n = {16'd0, v.hi, v.lo};
        if (v.exp_err) begin
            chk("err_overflow", 32'(err_overflow), 32'd1);
            chk("err_cpu_hold", 32'(cpu_hold), 32'd1);
            chk("err_byte_ready", 32'(byte_ready), 32'd0);
            chk("err_done", 32'(done), 32'd0);
            byte_valid = 1'b1;
            byte_data  = 8'hA5;
            repeat (5) @(negedge clk);
            chk("err_sticky", 32'(err_overflow), 32'd1);
            chk("err_byte_ready_held", 32'(byte_ready), 32'd0);
            byte_valid = 1'b0;
        end else if (n == 0) begin
            chk("n0_flush_done", 32'(done), 32'd0);
            @(negedge clk);
            chk("n0_done", 32'(done), 32'd1);
            chk("n0_cpu_hold", 32'(cpu_hold), 32'd0);
        end else begin
            for (int w = 0; w < v.nwords; w++) begin
                word = '0;
                for (int k = 0; k < 4; k++) begin
                    b = v.spec_data ? spec_bytes[w*4+k] : 8'($urandom);
                    word[k*8 +: 8] = b;
                    if (k == 3) sb.push_back('{addr: w, data: word});
                    send_byte(b, $urandom_range(v.maxgap, 0));
                end
            end
            chk("final_wr_en", 32'(wr_en), 32'd1);
            chk("final_not_done", 32'(done), 32'd0);
            chk("final_hold", 32'(cpu_hold), 32'd1);
            @(negedge clk);
            chk("release_wr_en", 32'(wr_en), 32'd0);
            chk("done", 32'(done), 32'd1);
            chk("cpu_hold_released", 32'(cpu_hold), 32'd0);
            chk("done_byte_ready", 32'(byte_ready), 32'd0);
        end
        chk("word_count", 32'(word_count), v.exp_wc);
        chk("writes_drained", sb.size(), 0);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd1);
        chk({tag, "_byte_ready"}, 32'(byte_ready), 32'd0);
        chk({tag, "_wr_en"}, 32'(wr_en), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_err"}, 32'(err_overflow), 32'd0);
        chk({tag, "_word_count"}, 32'(word_count), 32'd0);
        chk({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
        chk({tag, "_wr_data"}, wr_data, 32'd0);
    endtask

    initial begin
        logic [31:0] w0;
        spec_bytes = '{8'hB3, 8'h82, 8'h41, 8'h00, 8'h33, 8'h04, 8'h94, 8'h40};
        //          lo     hi     nw  gap spec err wc
        vecs[0] = '{8'h02, 8'h00, 2,  0,  1,   0,  2};
        vecs[1] = '{8'h02, 8'h00, 2,  5,  1,   0,  2};
        vecs[2] = '{8'h00, 8'h00, 0,  0,  0,   0,  0};
        vecs[3] = '{8'h41, 8'h00, 0,  0,  0,   1,  0};
        vecs[4] = '{8'h40, 8'h00, 64, 0,  0,   0,  64};
        vecs[5] = '{8'h01, 8'h00, 1,  2,  0,   0,  1};
        vecs[6] = '{8'h01, 8'h01, 0,  1,  0,   1,  0};

        reset = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
        repeat (3) @(negedge clk);
        chk_reset_values("rst");
        reset = 1'b0;
        @(negedge clk);
        chk_reset_values("idle");

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Reset after 5 data bytes of a 2-word load: only addr0 is written.
        do_start();
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        w0 = '0;
        for (int k = 0; k < 5; k++) begin
            if (k < 4) w0[k*8 +: 8] = spec_bytes[k];
            if (k == 3) sb.push_back('{addr: 0, data: w0});
            send_byte(spec_bytes[k], 0);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk_reset_values("midrst");
        repeat (10) @(negedge clk);
        chk("midrst_drained", sb.size(), 0);

        // Complete a short load, then assert reset and start together.
        run_vec(vecs[2]);
        reset = 1'b1;
        start = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        chk_reset_values("rststart");
        repeat (3) @(negedge clk);
        chk("rststart_no_clear", 32'(wr_en), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
